// File: rtl/reg_file_wb.sv
// 32x32 general register file at the write-back end of the datapath: one write port, two operand reads, one debug read.
// Optional write-through forwarding on the operand ports is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RA_IDX = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        regDst,
    input  logic              regWrite,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData,
    output logic [ADDR_W-1:0] wrDst
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [ADDR_W-1:0] wr_dst;
    logic              wr_en;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    // regDst=11 means "no write"; report index 0 so hazard logic sees nothing.
    always_comb begin
        wr_dst = '0;
        case (regDst)
            2'b00:   wr_dst = rt;
            2'b01:   wr_dst = rd;
            2'b10:   wr_dst = ADDR_W'(RA_IDX);
            default: wr_dst = '0;
        endcase
    end

    assign wrDst = wr_dst;
    assign wr_en = regWrite && (regDst != 2'b11) && (wr_dst != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_dst] = wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign stored1 = (rs == '0) ? '0 : regs_q[rs];
    assign stored2 = (rt == '0) ? '0 : regs_q[rt];
    assign dbgData = (dbgAddr == '0) ? '0 : regs_q[dbgAddr];

`ifdef REG_FILE_BYPASS_EN
    // Forward the pending write-back word; suppressed while reset holds the array cleared.
    logic byp1;
    logic byp2;
    assign byp1      = rst_n && wr_en && (rs == wr_dst);
    assign byp2      = rst_n && wr_en && (rt == wr_dst);
    assign readData1 = byp1 ? wrData : stored1;
    assign readData2 = byp2 ? wrData : stored2;
`else
    assign readData1 = stored1;
    assign readData2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: vector table, random write/read scoreboard, and hand sequences for reset and hazards.
// Build with REG_FILE_BYPASS_EN defined to check the forwarding variant.
module tb_reg_file_wb;
  logic        clk;
  logic        rst_n;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [1:0]  regDst;
  logic        regWrite;
  logic [31:0] wrData;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;
  logic [4:0]  wrDst;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[32];

  typedef struct {
    logic [1:0]  reg_dst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] data;
    logic [4:0]  exp_dst;
    logic [4:0]  chk_idx;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[10];

  reg_file_wb dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
    .regDst(regDst), .regWrite(regWrite), .wrData(wrData),
    .readData1(readData1), .readData2(readData2),
    .dbgAddr(dbgAddr), .dbgData(dbgData), .wrDst(wrDst)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, req);
    end
  endtask

  function automatic logic [4:0] model_dst(input logic [1:0] sel, input logic [4:0] t, input logic [4:0] d);
    case (sel)
      2'b00:   return t;
      2'b01:   return d;
      2'b10:   return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  // driver: apply one write-back cycle, check the resolved destination before the edge
  task automatic drive_write(input logic [1:0] sel, input logic [4:0] t, input logic [4:0] d,
                             input logic we, input logic [31:0] data, input logic [4:0] exp_dst);
    @(negedge clk);
    regDst = sel; rt = t; rd = d; regWrite = we; wrData = data;
    #1 chk("wr_dst", {27'd0, wrDst}, {27'd0, exp_dst});
    @(posedge clk);
    #1 regWrite = 1'b0;
    if (we && sel != 2'b11 && model_dst(sel, t, d) != 5'd0) model[model_dst(sel, t, d)] = data;
  endtask

  // scoreboard: expectation queued with the read stimulus, popped when the ports settle
  task automatic check_read(input logic [4:0] idx, input logic [31:0] exp_val);
    logic [31:0] e;
    exp_q.push_back(exp_val);
    rs = idx; rt = idx; dbgAddr = idx;
    #1;
    e = exp_q.pop_front();
    chk("rd1", readData1, e);
    chk("rd2", readData2, e);
    chk("dbg", dbgData, e);
  endtask

  initial begin
    vecs[0] = '{2'b00, 5'd3,  5'd0, 1'b1, 32'h0000_0011, 5'd3,  5'd3,  32'h0000_0011};
    vecs[1] = '{2'b01, 5'd0,  5'd4, 1'b1, 32'h0000_0022, 5'd4,  5'd4,  32'h0000_0022};
    vecs[2] = '{2'b10, 5'd6,  5'd8, 1'b1, 32'h0040_0008, 5'd31, 5'd31, 32'h0040_0008};
    vecs[3] = '{2'b01, 5'd0,  5'd0, 1'b1, 32'h1234_5678, 5'd0,  5'd0,  32'h0000_0000};
    vecs[4] = '{2'b11, 5'd3,  5'd4, 1'b1, 32'h0000_0099, 5'd0,  5'd3,  32'h0000_0011};
    vecs[5] = '{2'b01, 5'd0,  5'd9, 1'b0, 32'hFFFF_FFFF, 5'd9,  5'd9,  32'h0000_0000};
    vecs[6] = '{2'b00, 5'd1,  5'd0, 1'b1, 32'h0000_0001, 5'd1,  5'd1,  32'h0000_0001};
    vecs[7] = '{2'b01, 5'd0,  5'd2, 1'b1, 32'h0000_0002, 5'd2,  5'd2,  32'h0000_0002};
    vecs[8] = '{2'b00, 5'd0,  5'd7, 1'b1, 32'h0000_ABCD, 5'd0,  5'd0,  32'h0000_0000};
    vecs[9] = '{2'b11, 5'd4,  5'd4, 1'b1, 32'h5555_AAAA, 5'd0,  5'd4,  32'h0000_0022};

    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst_n = 1'b0; rs = '0; rt = '0; rd = '0; regDst = 2'b00;
    regWrite = 1'b0; wrData = '0; dbgAddr = '0;

    // reset state
    #12;
    check_read(5'd5, 32'd0);
    check_read(5'd31, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 10; i++) begin
      drive_write(vecs[i].reg_dst, vecs[i].rt, vecs[i].rd, vecs[i].reg_write, vecs[i].data, vecs[i].exp_dst);
      check_read(vecs[i].chk_idx, vecs[i].exp_val);
    end

    // dual read and debug port independence
    rs = 5'd1; rt = 5'd2; dbgAddr = 5'd2;
    #1;
    chk("dual_rd1", readData1, 32'h1);
    chk("dual_rd2", readData2, 32'h2);
    chk("dual_dbg", dbgData, 32'h2);
    rs = 5'd2; rt = 5'd2; dbgAddr = 5'd31;
    #1;
    chk("same_rd1", readData1, 32'h2);
    chk("same_rd2", readData2, 32'h2);
    chk("same_dbg", dbgData, 32'h0040_0008);

    // random write-back traffic against the bench model
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  s;
      logic [4:0]  t;
      logic [4:0]  d;
      logic        we;
      logic [31:0] data;
      logic [4:0]  idx;
      s = 2'($urandom_range(0, 3));
      t = 5'($urandom_range(0, 31));
      d = 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 3) != 0);
      data = $urandom;
      drive_write(s, t, d, we, data, model_dst(s, t, d));
      idx = (n % 2 == 0) ? model_dst(s, t, d) : 5'($urandom_range(0, 31));
      check_read(idx, model[idx]);
    end

    // same-cycle read/write hazard on r7
    drive_write(2'b00, 5'd7, 5'd0, 1'b1, 32'hA, 5'd7);
    @(negedge clk);
    rs = 5'd7; dbgAddr = 5'd7; regDst = 2'b00; rt = 5'd7; regWrite = 1'b1; wrData = 32'hB;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("haz_pre_rd1", readData1, 32'hB);
    chk("haz_pre_rd2", readData2, 32'hB);
`else
    chk("haz_pre_rd1", readData1, 32'hA);
    chk("haz_pre_rd2", readData2, 32'hA);
`endif
    chk("haz_pre_dbg", dbgData, 32'hA);
    @(posedge clk);
    #1 regWrite = 1'b0;
    model[7] = 32'hB;
    chk("haz_post_rd1", readData1, 32'hB);
    chk("haz_post_dbg", dbgData, 32'hB);

    // asynchronous reset mid-cycle, writes blocked while held
    drive_write(2'b00, 5'd5, 5'd0, 1'b1, 32'hDEAD_BEEF, 5'd5);
    rs = 5'd5; rt = 5'd5; dbgAddr = 5'd7;
    #1 chk("pre_rst_rd1", readData1, 32'hDEAD_BEEF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", readData1, 32'd0);
    chk("async_rst_dbg", dbgData, 32'd0);
    regDst = 2'b01; rd = 5'd5; regWrite = 1'b1; wrData = 32'hCAFE_F00D;
    #1;
    chk("rst_byp_rd1", readData1, 32'd0);
    chk("rst_byp_rd2", readData2, 32'd0);
    @(posedge clk);
    #1 chk("rst_hold_rd1", readData1, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("rel_pre_rd1", readData1, 32'hCAFE_F00D);
`else
    chk("rel_pre_rd1", readData1, 32'd0);
`endif
    @(posedge clk);
    #1 regWrite = 1'b0;
    model[5] = 32'hCAFE_F00D;
    check_read(5'd5, model[5]);
    check_read(5'd31, model[31]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
